btn_conditioner: RTL

Per-button front-end conditioner for the doorlock start and end push-buttons; sits directly upstream of the doorlock control FSMs in place of the inverter-plus-debouncer pair.
- Synchronises a raw, bouncing button input and removes contact bounce.
- Emits a debounced level plus single-cycle press, release and long-press pulses for the FSMs to consume.
- Instantiated once per button.

---
 rtl/btn_conditioner.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/btn_conditioner.sv
// Button front-end: 2-flop sync, debounce FSM, press/release/long-press pulses.
// Optional macro AUTO_REPEAT_EN: repeat press_pulse every REPEAT_CYC cycles while in LONG.
module btn_conditioner #(
    parameter int DEBOUNCE_CYC = 500000,
    parameter int LONG_CYC     = 100000000,
    parameter int REPEAT_CYC   = 10000000,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse
);
    localparam logic IDLE_PIN = (ACTIVE_LOW != 0);
    localparam int   DBW      = $clog2(DEBOUNCE_CYC);
    localparam int   HOLD_MAX = (LONG_CYC > REPEAT_CYC) ? LONG_CYC : REPEAT_CYC;
    localparam int   HW       = $clog2(HOLD_MAX);
    localparam logic [DBW-1:0] DB_LAST   = DBW'(DEBOUNCE_CYC - 1);
    localparam logic [HW-1:0]  LONG_LAST = HW'(LONG_CYC - 1);
`ifdef AUTO_REPEAT_EN
    localparam logic [HW-1:0]  REP_LAST  = HW'(REPEAT_CYC - 1);
`endif

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        DB_PRESS   = 3'd1,
        PRESSED    = 3'd2,
        LONG       = 3'd3,
        DB_RELEASE = 3'd4
    } state_t;

    state_t         state_q, state_d;
    logic           sync1_q, sync2_q;
    logic [DBW-1:0] db_cnt_q, db_cnt_d;
    logic [HW-1:0]  hold_cnt_q, hold_cnt_d;
    logic           ret_long_q, ret_long_d;
    logic           level_q, level_d;
    logic           press_q, press_d;
    logic           rel_q, rel_d;
    logic           long_q, long_d;
    logic           p;

    assign p             = sync2_q ^ IDLE_PIN;
    assign btn_level     = level_q;
    assign press_pulse   = press_q;
    assign release_pulse = rel_q;
    assign long_pulse    = long_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= IDLE_PIN;
            sync2_q    <= IDLE_PIN;
            state_q    <= IDLE;
            db_cnt_q   <= '0;
            hold_cnt_q <= '0;
            ret_long_q <= 1'b0;
            level_q    <= 1'b0;
            press_q    <= 1'b0;
            rel_q      <= 1'b0;
            long_q     <= 1'b0;
        end else begin
            sync1_q    <= btn_raw;
            sync2_q    <= sync1_q;
            state_q    <= state_d;
            db_cnt_q   <= db_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            ret_long_q <= ret_long_d;
            level_q    <= level_d;
            press_q    <= press_d;
            rel_q      <= rel_d;
            long_q     <= long_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        db_cnt_d   = db_cnt_q;
        hold_cnt_d = hold_cnt_q;
        ret_long_d = ret_long_q;
        level_d    = level_q;
        press_d    = 1'b0;
        rel_d      = 1'b0;
        long_d     = 1'b0;
        case (state_q)
            IDLE: begin
                level_d    = 1'b0;
                hold_cnt_d = '0;
                if (p) begin
                    state_d  = DB_PRESS;
                    db_cnt_d = DBW'(1);
                end
            end
            DB_PRESS: begin
                if (!p) begin
                    state_d  = IDLE;
                    db_cnt_d = '0;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d    = PRESSED;
                    level_d    = 1'b1;
                    press_d    = 1'b1;
                    hold_cnt_d = '0;
                    db_cnt_d   = '0;
                end else begin
                    db_cnt_d = db_cnt_q + 1'b1;
                end
            end
            PRESSED: begin
                // A release glitch outranks the long-press threshold on the same cycle.
                if (!p) begin
                    state_d    = DB_RELEASE;
                    db_cnt_d   = DBW'(1);
                    ret_long_d = 1'b0;
                end else if (hold_cnt_q == LONG_LAST) begin
                    state_d    = LONG;
                    long_d     = 1'b1;
                    hold_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            LONG: begin
                if (!p) begin
                    state_d    = DB_RELEASE;
                    db_cnt_d   = DBW'(1);
                    ret_long_d = 1'b1;
                end
`ifdef AUTO_REPEAT_EN
                else if (hold_cnt_q == REP_LAST) begin
                    press_d    = 1'b1;
                    hold_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
`endif
            end
            DB_RELEASE: begin
                if (p) begin
                    state_d  = ret_long_q ? LONG : PRESSED;
                    db_cnt_d = '0;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d    = IDLE;
                    level_d    = 1'b0;
                    rel_d      = 1'b1;
                    db_cnt_d   = '0;
                    hold_cnt_d = '0;
                end else begin
                    db_cnt_d = db_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                level_d = 1'b0;
            end
        endcase
    end
endmodule
